spi_slave_fsm: RTL and testbench

SPI responder (slave) for our single-byte SPI link. It receives MOSI bytes from `spi_master_fsm` and returns one byte per frame on MISO. All pins are oversampled and synchronised into the local system clock, so the responder's `clk` need not be related to the master's. A valid/ready TX buffer and a one-cycle RX strobe connect it to local logic; back-to-back bytes under one CS assertion are supported.

---
 rtl/spi_slave_fsm.sv | 191 +++++++++++++++++++
 tb/tb_spi_slave_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fsm.sv
// SPI responder: oversamples SCLK/CS/MOSI into clk, receives MSB-first bytes on
// SCLK falling edges and returns one buffered (or default) byte per byte slot.
module spi_slave_fsm #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       abort,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state_r, state_nxt;
  logic       sclk_meta_r, sclk_sync_r, sclk_dly_r;
  logic       cs_meta_r, cs_sync_r, cs_dly_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [1:0] warm_r;
  logic       armed_r;
  logic       sclk_fall_s, cs_fall_s, cs_rise_s;

  logic [7:0] sh_tx_r, sh_tx_nxt;
  logic [7:0] sh_rx_r, sh_rx_nxt;
  logic [2:0] bit_cnt_r, bit_cnt_nxt;
  logic [7:0] tx_buf_r, tx_buf_nxt;
  logic       tx_full_r, tx_full_nxt;
  logic       miso_r, miso_nxt;
  logic [7:0] rx_data_r, rx_data_nxt;
  logic       rx_valid_r, rx_valid_nxt;
  logic       underrun_r, underrun_nxt;
  logic       abort_r, abort_nxt;
  logic       consume_s, write_s;
  logic [7:0] load_byte_s;

  // Two-flop synchronisers plus edge-detect delay flops; armed_r blocks a
  // frame already in progress at reset release from looking like a CS fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_dly_r  <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_dly_r    <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      warm_r      <= 2'b00;
      armed_r     <= 1'b0;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_dly_r  <= sclk_sync_r;
      cs_meta_r   <= cs;
      cs_sync_r   <= cs_meta_r;
      cs_dly_r    <= cs_sync_r;
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
      warm_r      <= {warm_r[0], 1'b1};
      armed_r     <= armed_r | (warm_r[1] & cs_sync_r);
    end
  end

  assign sclk_fall_s = sclk_dly_r & ~sclk_sync_r;
  assign cs_fall_s   = armed_r & cs_dly_r & ~cs_sync_r;
  assign cs_rise_s   = ~cs_dly_r & cs_sync_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, shift registers, TX buffer and pulse outputs
  always_comb begin
    state_nxt    = state_r;
    sh_tx_nxt    = sh_tx_r;
    sh_rx_nxt    = sh_rx_r;
    bit_cnt_nxt  = bit_cnt_r;
    miso_nxt     = miso_r;
    rx_data_nxt  = rx_data_r;
    rx_valid_nxt = 1'b0;
    abort_nxt    = 1'b0;
    consume_s    = 1'b0;
    load_byte_s  = tx_full_r ? tx_buf_r : DEFAULT_TX;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_nxt   = ACTIVE;
          consume_s   = 1'b1;
          bit_cnt_nxt = 3'd0;
          sh_tx_nxt   = load_byte_s;
          miso_nxt    = load_byte_s[7];
        end else begin
          state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        // CS rising beats a coincident SCLK fall: the bit is not sampled.
        if (cs_rise_s) begin
          state_nxt   = IDLE;
          abort_nxt   = (bit_cnt_r != 3'd0);
          bit_cnt_nxt = 3'd0;
          miso_nxt    = 1'b0;
        end else if (sclk_fall_s) begin
          sh_rx_nxt   = {sh_rx_r[6:0], mosi_sync_r};
          bit_cnt_nxt = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            rx_data_nxt  = {sh_rx_r[6:0], mosi_sync_r};
            rx_valid_nxt = 1'b1;
            consume_s    = 1'b1;
            sh_tx_nxt    = load_byte_s;
            miso_nxt     = load_byte_s[7];
          end else begin
            sh_tx_nxt = {sh_tx_r[6:0], 1'b0};
            miso_nxt  = sh_tx_r[6];
          end
        end else begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt = IDLE;
        miso_nxt  = 1'b0;
      end
    endcase
    underrun_nxt = consume_s & ~tx_full_r;
    // A same-cycle write lands after the consume, so it refills the buffer.
    write_s    = tx_valid & ~tx_full_r;
    tx_buf_nxt = tx_buf_r;
    if (write_s) begin
      tx_full_nxt = 1'b1;
      tx_buf_nxt  = tx_data;
    end else if (consume_s) begin
      tx_full_nxt = 1'b0;
    end else begin
      tx_full_nxt = tx_full_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_tx_r    <= 8'h00;
      sh_rx_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      tx_buf_r   <= 8'h00;
      tx_full_r  <= 1'b0;
      miso_r     <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
      abort_r    <= 1'b0;
    end else begin
      sh_tx_r    <= sh_tx_nxt;
      sh_rx_r    <= sh_rx_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      tx_buf_r   <= tx_buf_nxt;
      tx_full_r  <= tx_full_nxt;
      miso_r     <= miso_nxt;
      rx_data_r  <= rx_data_nxt;
      rx_valid_r <= rx_valid_nxt;
      underrun_r <= underrun_nxt;
      abort_r    <= abort_nxt;
    end
  end

  assign miso        = miso_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = underrun_r;
  assign abort       = abort_r;
  assign tx_ready    = ~tx_full_r;
  assign busy        = (state_r == ACTIVE);

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: bench-driven SPI master, table of
// single-byte frames, hand-written multi-byte/abort/reset/hold sequences.
module tb_spi_slave_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       abort;
  logic       busy;

  spi_slave_fsm #(.DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] mi_byte;
  logic rxv_prev = 1'b0, und_prev = 1'b0, abt_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops expected rx bytes, checks pulse widths
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rxv_cnt++;
        check("rx_valid_width", {31'd0, rxv_prev}, 32'd0);
        if (rx_exp_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
        else check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
      end
      if (tx_underrun) begin
        und_cnt++;
        check("underrun_width", {31'd0, und_prev}, 32'd0);
      end
      if (abort) begin
        abt_cnt++;
        check("abort_width", {31'd0, abt_prev}, 32'd0);
      end
    end
    rxv_prev = rx_valid;
    und_prev = tx_underrun;
    abt_prev = abort;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] b);
    check("tx_ready_before_write", {31'd0, tx_ready}, 32'd1);
    tx_data = b;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_assert();
    wait_clk(1);
    cs = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_deassert();
    wait_clk(4);
    cs = 1'b1;
    wait_clk(6);
  endtask

  // Drive bits [from..to] (0 = MSB); MOSI changes on rise, MISO sampled before fall
  task automatic spi_bits(input logic [7:0] mo, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      sclk = 1'b1;
      mosi = mo[7-i];
      wait_clk(4);
      mi_byte[7-i] = miso;
      sclk = 1'b0;
      wait_clk(4);
    end
  endtask

  typedef struct {
    logic       preload;
    logic [7:0] tx_byte;
    logic [7:0] mosi_byte;
    logic [7:0] exp_miso;
    int         exp_underruns;
  } vec_t;

  vec_t vecs[4];
  int rx0, un0, ab0;

  initial begin
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 1};
    vecs[1] = '{1'b0, 8'h00, 8'h0F, 8'hFF, 2};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
    vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 1};

    wait_clk(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {29'd0, rx_valid, tx_underrun, abort}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    for (int v = 0; v < 4; v++) begin
      rx0 = rxv_cnt; un0 = und_cnt;
      if (vecs[v].preload) tx_write(vecs[v].tx_byte);
      rx_exp_q.push_back(vecs[v].mosi_byte);
      cs_assert();
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      check("tx_ready_at_start", {31'd0, tx_ready}, 32'd1);
      spi_bits(vecs[v].mosi_byte, 0, 7);
      cs_deassert();
      check("vec_miso", {24'd0, mi_byte}, {24'd0, vecs[v].exp_miso});
      check("vec_rx_count", rxv_cnt - rx0, 1);
      check("vec_underruns", und_cnt - un0, vecs[v].exp_underruns);
      check("busy_after", {31'd0, busy}, 32'd0);
    end

    // Back-to-back bytes under one CS
    rx0 = rxv_cnt; un0 = und_cnt;
    tx_write(8'h3C);
    rx_exp_q.push_back(8'h12);
    rx_exp_q.push_back(8'h34);
    cs_assert();
    spi_bits(8'h12, 0, 3);
    tx_write(8'hC3);
    spi_bits(8'h12, 4, 7);
    check("b2b_miso0", {24'd0, mi_byte}, 32'h3C);
    spi_bits(8'h34, 0, 7);
    check("b2b_miso1", {24'd0, mi_byte}, 32'hC3);
    cs_deassert();
    check("b2b_rx_count", rxv_cnt - rx0, 2);
    check("b2b_underruns", und_cnt - un0, 1);

    // Abort after 5 falling edges
    rx0 = rxv_cnt; ab0 = abt_cnt;
    cs_assert();
    spi_bits(8'hF0, 0, 4);
    cs_deassert();
    check("abort_count", abt_cnt - ab0, 1);
    check("abort_no_rx", rxv_cnt - rx0, 0);
    check("abort_rx_hold", {24'd0, rx_data}, 32'h34);
    rx_exp_q.push_back(8'h99);
    cs_assert();
    spi_bits(8'h99, 0, 7);
    cs_deassert();
    check("post_abort_miso", {24'd0, mi_byte}, 32'hFF);
    check("post_abort_rx", rxv_cnt - rx0, 1);

    // Reset in the middle of a frame
    tx_write(8'h77);
    cs_assert();
    spi_bits(8'hC5, 0, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_pulses", {29'd0, rx_valid, tx_underrun, abort}, 32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    rx0 = rxv_cnt; ab0 = abt_cnt;
    spi_bits(8'hC5, 3, 7);
    cs_deassert();
    check("post_rst_no_rx", rxv_cnt - rx0, 0);
    check("post_rst_no_abort", abt_cnt - ab0, 0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    rx_exp_q.push_back(8'h5A);
    cs_assert();
    spi_bits(8'h5A, 0, 7);
    cs_deassert();
    check("post_rst_miso", {24'd0, mi_byte}, 32'hFF);
    check("post_rst_rx", rxv_cnt - rx0, 1);

    // tx_valid held while buffer full: no overwrite
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      check("hold_tx_ready_low", {31'd0, tx_ready}, 32'd0);
      wait_clk(1);
    end
    tx_valid = 1'b0;
    rx_exp_q.push_back(8'h11);
    cs_assert();
    spi_bits(8'h11, 0, 7);
    cs_deassert();
    check("hold_miso", {24'd0, mi_byte}, 32'hAA);
    check("hold_tx_ready_after", {31'd0, tx_ready}, 32'd1);

    check("rx_queue_empty", rx_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
